// File: rtl/color_run_tracker.sv
`default_nettype none
// ============================================================================
// color_run_tracker : run-length encoder for a Blue/Red color stream feeding
//                     a small record FIFO.                       rev 1.0
// ============================================================================
module color_run_tracker #(
    parameter int LEN_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 color_in,
    input  logic                       color_valid,
    input  logic                       flush,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [1:0]                 rec_color,
    output logic [LEN_WIDTH-1:0]       rec_len,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int                   PTR_W      = $clog2(DEPTH);
    localparam int                   CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]     FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX    = '1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [1:0]           cur_color, cur_color_next;
    logic [LEN_WIDTH-1:0] cur_len, cur_len_next;
    logic                 legal;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 accept;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [1:0]           mem_color [DEPTH];
    logic [LEN_WIDTH-1:0] mem_len   [DEPTH];

    assign legal = (color_in == 2'h1) || (color_in == 2'h2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_color <= '0;
            cur_len   <= '0;
        end else begin
            state     <= state_next;
            cur_color <= cur_color_next;
            cur_len   <= cur_len_next;
        end
    end

    // push marks a run closing this cycle; the record is (cur_color, cur_len)
    always_comb begin
        state_next     = state;
        cur_color_next = cur_color;
        cur_len_next   = cur_len;
        push           = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && color_valid && legal) begin
                    state_next     = RUN;
                    cur_color_next = color_in;
                    cur_len_next   = LEN_WIDTH'(1);
                end
            end
            RUN: begin
                if (flush) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end else if (color_valid) begin
                    if (!legal) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else if (color_in == cur_color) begin
                        if (cur_len != LEN_MAX) begin
                            cur_len_next = cur_len + LEN_WIDTH'(1);
                        end
                    end else begin
                        push           = 1'b1;
                        cur_color_next = color_in;
                        cur_len_next   = LEN_WIDTH'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign full      = (count == FULL_COUNT);
    assign rec_valid = (count != '0);
    assign pop       = rec_valid && rec_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign accept    = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_color[wr_ptr] <= cur_color;
            mem_len[wr_ptr]   <= cur_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !accept) begin
                overflow <= 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rec_color = rec_valid ? mem_color[rd_ptr] : 2'b00;
    assign rec_len   = rec_valid ? mem_len[rd_ptr]   : '0;

endmodule
`default_nettype wire
